// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 prefix codes, tracker state encoding and the optional scan-to-ASCII lookup.
// Macro PS2_ASCII_LUT_EN: when defined, ps2_ascii() maps set-2 make codes a-z, 0-9,
// space and enter to ASCII; unmapped codes give 8'h00.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {IDLE, EXT, BREAK, EXT_BRK} trk_state_t;

`ifdef PS2_ASCII_LUT_EN
    function automatic logic [7:0] ps2_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
            8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
            8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
            8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
            8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
            8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
            8'h3E: return 8'h38; 8'h46: return 8'h39;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            default: return 8'h00;
        endcase
    endfunction
`endif

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 lines, assembles 11-bit frames and validates them.
// Ports: clk, resetn (async, active-low); ps2_clk, ps2_data (raw, asynchronous);
//        rx_byte (data byte of the last frame), byte_vld (1-cycle pulse, frame good),
//        frame_err (1-cycle pulse, bad start/parity/stop). A stalled partial frame is
//        silently dropped after TIMEOUT_CYCLES clocks without a ps2_clk falling edge.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]      clk_s;
    logic [1:0]      dat_s;
    logic [9:0]      shift;
    logic [3:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            fall;
    logic            last;
    logic            good;
    logic            timeout;

    // clk_s[1] is the synchronised clock, clk_s[2] its previous value; dat_s[1] lines up with clk_s[1].
    assign fall    = clk_s[2] & ~clk_s[1];
    assign last    = bit_cnt == 4'd10;
    // shift holds {parity, data[7:0], start}; the stop bit is still on the data line at the last edge.
    assign good    = ~shift[0] & dat_s[1] & ^shift[9:1];
    assign timeout = bit_cnt != 4'd0 && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign rx_byte = shift[8:1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s     <= '1;
            dat_s     <= '1;
            shift     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_s     <= {clk_s[1:0], ps2_clk};
            dat_s     <= {dat_s[0], ps2_data};
            byte_vld  <= fall & last & good;
            frame_err <= fall & last & ~good;
            to_cnt    <= (fall || bit_cnt == 4'd0 || timeout) ? '0 : to_cnt + 1'b1;
            if (fall) begin
                bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
                // The stop bit is not shifted so rx_byte stays stable while byte_vld is high.
                if (!last)
                    shift <= {dat_s[1], shift[9:1]};
            end else if (timeout) begin
                bit_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 make/break/extended sequences into the current key state.
// Ports: clk, resetn (async, active-low); ps2_clk, ps2_data (raw PS/2 lines);
//        scan_code (last make code, E0 stripped), ascii (lookup of scan_code, 0 when the
//        LUT is disabled), key_count (distinct presses, wraps), key_down (scan_code held),
//        frame_err (1-cycle pulse per rejected frame).
// Macro PS2_ASCII_LUT_EN enables the registered ASCII lookup; otherwise ascii is tied to 0.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [7:0]       scan_code,
    output logic [7:0]       ascii,
    output logic [CNT_W-1:0] key_count,
    output logic             key_down,
    output logic             frame_err
);

    trk_state_t       state_q;
    trk_state_t       state_d;
    logic [7:0]       rx_byte;
    logic             byte_vld;
    logic [7:0]       scan_d;
    logic [CNT_W-1:0] cnt_d;
    logic             down_d;
    logic             make;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_vld  (byte_vld),
        .frame_err (frame_err)
    );

    always_comb begin
        state_d = state_q;
        scan_d  = scan_code;
        cnt_d   = key_count;
        down_d  = key_down;
        make    = 1'b0;
        if (byte_vld) begin
            case (state_q)
                IDLE: begin
                    state_d = rx_byte == PS2_BREAK ? BREAK : rx_byte == PS2_EXT ? EXT : IDLE;
                    make    = rx_byte != PS2_BREAK && rx_byte != PS2_EXT;
                end
                EXT: begin
                    state_d = rx_byte == PS2_BREAK ? EXT_BRK : IDLE;
                    make    = rx_byte != PS2_BREAK;
                end
                default: begin
                    state_d = IDLE;
                    down_d  = rx_byte == scan_code ? 1'b0 : key_down;
                end
            endcase
        end
        // A typematic repeat of the held key refreshes state without counting a new press.
        if (make) begin
            cnt_d  = (!key_down || rx_byte != scan_code) ? key_count + 1'b1 : key_count;
            scan_d = rx_byte;
            down_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            scan_code <= '0;
            key_count <= '0;
            key_down  <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_code <= scan_d;
            key_count <= cnt_d;
            key_down  <= down_d;
        end
    end

`ifdef PS2_ASCII_LUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ascii <= '0;
        else
            ascii <= ps2_ascii(scan_d);
    end
`else
    assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: scoreboard bench driving PS/2 frames against a behavioural key model.
module tb_ps2_key_tracker;

    localparam int TO   = 1000;
    localparam int HALF = 6;
    localparam int GAP  = 30;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic [7:0] ascii;
    logic [7:0] key_count;
    logic       key_down;
    logic       frame_err;

    typedef struct {
        logic [7:0] scan;
        logic [7:0] asc;
        logic [7:0] cnt;
        logic       down;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    int   mon_falls = 0;
    int   mon_idle = 0;
    logic mon_prev = 1'b1;

    // Reference key state: last make code, held flag, press count and pending prefixes.
    logic [7:0] m_scan;
    logic [7:0] m_cnt;
    logic       m_down;
    logic       m_brk;
    logic       m_ext;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .ascii     (ascii),
        .key_count (key_count),
        .key_down  (key_down),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err) err_seen <= err_seen + 1;

    function automatic logic [7:0] ref_ascii(input logic [7:0] c);
        logic [7:0] a = 8'h00;
`ifdef PS2_ASCII_LUT_EN
        logic [7:0] keys [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45,
                                  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 36; i++)
            if (keys[i] == c) a = i < 26 ? 8'h61 + 8'(i) : 8'h30 + 8'(i - 26);
        if (c == 8'h29) a = 8'h20;
        if (c == 8'h5A) a = 8'h0D;
`else
        a = c & 8'h00;
`endif
        return a;
    endfunction

    function automatic void model_reset();
        m_scan = 8'h00;
        m_cnt  = 8'h00;
        m_down = 1'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
    endfunction

    // After F0 the next byte is a release; E0 only acts as a prefix once in a row.
    function automatic void model_byte(input logic [7:0] b);
        if (m_brk) begin
            if (b == m_scan) m_down = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0 && !m_ext) begin
            m_ext = 1'b1;
        end else begin
            if (!m_down || b != m_scan) m_cnt = m_cnt + 8'd1;
            m_scan = b;
            m_down = 1'b1;
            m_ext  = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        exp_t e;
        if (bad_par || bad_stop) err_exp++;
        else model_byte(b);
        e = '{m_scan, ref_ascii(m_scan), m_cnt, m_down, bad_par || bad_stop};
        q.push_back(e);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (GAP) @(negedge clk);
    endtask

    // Monitor: counts ps2_clk falls itself; the 11th fall of a burst is a stop bit, after which
    // frame_err is due two clocks later and the key outputs one clock after that.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (mon_prev && !ps2_clk) begin
                mon_falls++;
                mon_idle = 0;
            end else begin
                mon_idle++;
                if (mon_idle > 20) mon_falls = 0;
            end
            mon_prev = ps2_clk;
            if (mon_falls == 11) begin
                mon_falls = 0;
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL scoreboard: frame completed with no expectation queued");
                end else begin
                    e = q.pop_front();
                    check("frame_err pulse", 32'(frame_err), 32'(e.err));
                    @(posedge clk);
                    @(negedge clk);
                    check("frame_err width", 32'(frame_err), 32'd0);
                    check("scan_code", 32'(scan_code), 32'(e.scan));
                    check("ascii", 32'(ascii), 32'(e.asc));
                    check("key_count", 32'(key_count), 32'(e.cnt));
                    check("key_down", 32'(key_down), 32'(e.down));
                end
            end
        end
    end

    initial begin
        logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h21, 8'hF0, 8'hE0, 8'h45, 8'h29, 8'h5A,
                                  8'h75, 8'hF0, 8'h1C, 8'h16};
        logic [7:0] b;
        int r;
        model_reset();
        repeat (5) @(negedge clk);
        check("reset scan_code", 32'(scan_code), 32'd0);
        check("reset ascii", 32'(ascii), 32'd0);
        check("reset key_count", 32'(key_count), 32'd0);
        check("reset key_down", 32'(key_down), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle after reset", 32'({scan_code, ascii, key_count, key_down, frame_err}), 32'd0);

        send_frame(8'h1C);
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'h1C);
        send_frame(8'h1C);
        send_frame(8'h1C);
        send_frame(8'h32);
        send_frame(8'h15, 1'b1);

        send_bits(11'h000, 5);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h16);

        send_bits(11'h7FE, 5);
        reset_pulse();
        send_frame(8'h16);

        send_frame(8'hE0);
        send_frame(8'h75);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        send_frame(8'h21, 1'b0, 1'b1);

        reset_pulse();
        send_frame(8'h1C);
        for (int i = 0; i < 255; i++) send_frame(i % 2 == 0 ? 8'h32 : 8'h1C);
        check("key_count wrap", 32'(key_count), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 15));
            b = r < 12 ? pool[r] : 8'($urandom);
            r = int'($urandom_range(0, 9));
            send_frame(b, r == 0, r == 1);
        end

        repeat (50) @(negedge clk);
        check("scoreboard drained", 32'(q.size()), 32'd0);
        check("frame_err total", 32'(err_seen), 32'(err_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
